cci_mpf_prim_filter_cam_alloc: RTL and testbench

Parametrised successor to the MPF filter CAM. Stores up to N_ENTRIES values, answers "value not present" queries for several clients at a selectable pipeline latency, and owns its own slot allocation: free slots, occupancy count and full/empty status are tracked internally rather than by the instantiating code. Used by MPF ordering and hazard filters that previously managed CAM slot indices externally.

---
 rtl/cci_mpf_prim_filter_cam_alloc.sv | 156 +++++++++++++++
 tb/tb_cci_mpf_prim_filter_cam_alloc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_filter_cam_alloc.sv
// Filter CAM that owns its own slot allocation: lowest-free-slot insert, indexed remove,
// and multi-client "value not present" tests at a latency of 0, 1 or 2 cycles.
module cci_mpf_prim_filter_cam_alloc #(
  parameter int N_ENTRIES             = 16,
  parameter int VALUE_BITS            = 4,
  parameter int N_TEST_CLIENTS        = 1,
  parameter int TEST_LATENCY          = 1,
  parameter int BYPASS_INSERT_TO_TEST = 0,
  localparam int IDX_W = $clog2(N_ENTRIES),
  localparam int CNT_W = $clog2(N_ENTRIES + 1)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [N_TEST_CLIENTS-1:0][VALUE_BITS-1:0]  test_value_i,
  input  logic [N_TEST_CLIENTS-1:0]                  test_en_i,
  output logic [N_TEST_CLIENTS-1:0]                  test_notPresent_o,
  input  logic [VALUE_BITS-1:0]                      insert_value_i,
  input  logic                                       insert_en_i,
  output logic                                       insert_rdy_o,
  output logic [IDX_W-1:0]                           insert_idx_o,
  input  logic [IDX_W-1:0]                           remove_idx_i,
  input  logic                                       remove_en_i,
  output logic [CNT_W-1:0]                           n_valid_o,
  output logic                                       full_o,
  output logic                                       empty_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);

  logic [N_ENTRIES-1:0]  alloc_q, alloc_d, valid_q, valid_d;
  logic [VALUE_BITS-1:0] values_q [N_ENTRIES];
  logic                  stg_en_q;
  logic [IDX_W-1:0]      stg_idx_q;
  logic [VALUE_BITS-1:0] stg_val_q;
  logic [CNT_W-1:0]      n_valid_q, n_valid_d;

  logic [IDX_W-1:0]      free_idx;
  logic                  ins_acc, rem_eff;
  logic [N_ENTRIES-1:0]  ins_vec, rem_vec, wr_vec;

  always_comb begin
    free_idx = '0;
    for (int b = N_ENTRIES - 1; b >= 0; b--) begin
      if (!alloc_q[b]) free_idx = IDX_W'(b);
    end
  end

  // Status is forced to the post-reset view while reset is held so callers never see stale fullness.
  assign full_o       = !reset && (n_valid_q == FULL_CNT);
  assign empty_o      = reset || (n_valid_q == '0);
  assign insert_rdy_o = !reset && (n_valid_q != FULL_CNT);
  assign insert_idx_o = free_idx;
  assign n_valid_o    = n_valid_q;
  assign ins_acc      = insert_en_i && insert_rdy_o;

  always_comb begin
    ins_vec = '0;
    rem_vec = '0;
    wr_vec  = '0;
    for (int b = 0; b < N_ENTRIES; b++) begin
      ins_vec[b] = ins_acc && (free_idx == IDX_W'(b));
      rem_vec[b] = remove_en_i && (remove_idx_i == IDX_W'(b)) && alloc_q[b];
      // A remove of the slot being written this cycle wins, leaving it invalid.
      wr_vec[b]  = stg_en_q && (stg_idx_q == IDX_W'(b)) && !rem_vec[b];
    end
  end

  assign rem_eff = |rem_vec;
  assign alloc_d = (alloc_q | ins_vec) & ~rem_vec;
  assign valid_d = (valid_q | wr_vec) & ~rem_vec;

  always_comb begin
    n_valid_d = n_valid_q;
    if (ins_acc && !rem_eff)      n_valid_d = n_valid_q + 1'b1;
    else if (!ins_acc && rem_eff) n_valid_d = n_valid_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q   <= '0;
      valid_q   <= '0;
      stg_en_q  <= 1'b0;
      n_valid_q <= '0;
    end else begin
      alloc_q   <= alloc_d;
      valid_q   <= valid_d;
      stg_en_q  <= ins_acc;
      n_valid_q <= n_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_acc) begin
      stg_idx_q <= free_idx;
      stg_val_q <= insert_value_i;
    end
    for (int b = 0; b < N_ENTRIES; b++) begin
      if (wr_vec[b]) values_q[b] <= stg_val_q;
    end
  end

  logic [N_TEST_CLIENTS-1:0][N_ENTRIES-1:0] slot_hit;
  logic [N_TEST_CLIENTS-1:0]                fly_hit;
  logic [N_TEST_CLIENTS-1:0]                np_comb;

  always_comb begin
    slot_hit = '0;
    fly_hit  = '0;
    np_comb  = '1;
    for (int c = 0; c < N_TEST_CLIENTS; c++) begin
      for (int b = 0; b < N_ENTRIES; b++) begin
        slot_hit[c][b] = valid_q[b] && (values_q[b] == test_value_i[c]);
      end
      fly_hit[c] = (stg_en_q && (stg_val_q == test_value_i[c])) ||
                   ((BYPASS_INSERT_TO_TEST != 0) && ins_acc && (insert_value_i == test_value_i[c]));
      np_comb[c] = !(test_en_i[c] && ((|slot_hit[c]) || fly_hit[c]));
    end
  end

  generate
    if (TEST_LATENCY == 0) begin : g_lat0
      assign test_notPresent_o = np_comb;
    end else if (TEST_LATENCY == 1) begin : g_lat1
      logic [N_TEST_CLIENTS-1:0] np_q;
      always_ff @(posedge clk) begin
        if (reset) np_q <= '1;
        else       np_q <= np_comb;
      end
      assign test_notPresent_o = np_q;
    end else begin : g_lat2
      logic [N_TEST_CLIENTS-1:0][N_ENTRIES-1:0] s1_hit_q;
      logic [N_TEST_CLIENTS-1:0]                s1_fly_q, s1_en_q, s2_np_d, np_q;
      always_comb begin
        s2_np_d = '1;
        for (int c = 0; c < N_TEST_CLIENTS; c++) begin
          s2_np_d[c] = !(s1_en_q[c] && ((|s1_hit_q[c]) || s1_fly_q[c]));
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_hit_q <= '0;
          s1_fly_q <= '0;
          s1_en_q  <= '0;
          np_q     <= '1;
        end else begin
          s1_hit_q <= slot_hit;
          s1_fly_q <= fly_hit;
          s1_en_q  <= test_en_i;
          np_q     <= s2_np_d;
        end
      end
      assign test_notPresent_o = np_q;
    end
  endgenerate

endmodule

// File: tb/tb_cci_mpf_prim_filter_cam_alloc.sv
// Bench for the allocating filter CAM: three configurations share one insert/remove stream
// and are checked against a slot-set model with per-latency result history.
module tb_cci_mpf_prim_filter_cam_alloc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0][3:0] tv;
  logic [1:0]      ten;
  logic [3:0]      ins_val;
  logic            ins_en;
  logic [3:0]      rem_idx;
  logic            rem_en;

  logic [0:0] np_a;
  logic [1:0] np_b, np_c;
  logic       rdy_a, rdy_b, rdy_c, full_a, full_b, full_c, empty_a, empty_b, empty_c;
  logic [3:0] idx_a, idx_b, idx_c;
  logic [4:0] nv_a, nv_b, nv_c;

  cci_mpf_prim_filter_cam_alloc #(.N_ENTRIES(16), .VALUE_BITS(4), .N_TEST_CLIENTS(1),
    .TEST_LATENCY(1), .BYPASS_INSERT_TO_TEST(0)) dut_a (
    .clk(clk), .reset(reset), .test_value_i(tv[0]), .test_en_i(ten[0]), .test_notPresent_o(np_a),
    .insert_value_i(ins_val), .insert_en_i(ins_en), .insert_rdy_o(rdy_a), .insert_idx_o(idx_a),
    .remove_idx_i(rem_idx), .remove_en_i(rem_en), .n_valid_o(nv_a), .full_o(full_a), .empty_o(empty_a));

  cci_mpf_prim_filter_cam_alloc #(.N_ENTRIES(16), .VALUE_BITS(4), .N_TEST_CLIENTS(2),
    .TEST_LATENCY(2), .BYPASS_INSERT_TO_TEST(1)) dut_b (
    .clk(clk), .reset(reset), .test_value_i(tv), .test_en_i(ten), .test_notPresent_o(np_b),
    .insert_value_i(ins_val), .insert_en_i(ins_en), .insert_rdy_o(rdy_b), .insert_idx_o(idx_b),
    .remove_idx_i(rem_idx), .remove_en_i(rem_en), .n_valid_o(nv_b), .full_o(full_b), .empty_o(empty_b));

  cci_mpf_prim_filter_cam_alloc #(.N_ENTRIES(16), .VALUE_BITS(4), .N_TEST_CLIENTS(2),
    .TEST_LATENCY(0), .BYPASS_INSERT_TO_TEST(0)) dut_c (
    .clk(clk), .reset(reset), .test_value_i(tv), .test_en_i(ten), .test_notPresent_o(np_c),
    .insert_value_i(ins_val), .insert_en_i(ins_en), .insert_rdy_o(rdy_c), .insert_idx_o(idx_c),
    .remove_idx_i(rem_idx), .remove_en_i(rem_en), .n_valid_o(nv_c), .full_o(full_c), .empty_o(empty_c));

  int checks = 0;
  int errors = 0;

  // Model: which slots are owned, which hold searchable values, and the one in-flight insert.
  bit         m_alloc [16];
  bit         m_valid [16];
  logic [3:0] m_val   [16];
  bit         m_fly_en;
  int         m_fly_idx;
  logic [3:0] m_fly_val;

  int   e_nv, e_idx;
  bit   e_rdy, e_full, e_empty, e_acc;
  bit   e_np_a;
  bit   [1:0] e_np_b, e_np_c;
  bit   cur_a;
  bit   [1:0] cur_b, cur_c;
  bit   h_a1;
  bit   [1:0] h_b1, h_b2;
  bit   rst1 = 1'b1, rst2 = 1'b1;

  function automatic bit present(input logic [3:0] v, input bit byp);
    bit hit = 1'b0;
    for (int b = 0; b < 16; b++) if (m_valid[b] && m_val[b] == v) hit = 1'b1;
    if (m_fly_en && m_fly_val == v) hit = 1'b1;
    if (byp && e_acc && ins_val == v) hit = 1'b1;
    return hit;
  endfunction

  task automatic settle();
    int cnt = 0;
    @(negedge clk);
    e_idx = -1;
    for (int b = 15; b >= 0; b--) begin
      if (m_alloc[b]) cnt++;
      else e_idx = b;
    end
    e_nv    = cnt;
    e_full  = !reset && cnt == 16;
    e_empty = reset || cnt == 0;
    e_rdy   = !reset && cnt < 16;
    e_acc   = ins_en && e_rdy;
    cur_a   = !(ten[0] && present(tv[0], 1'b0));
    for (int c = 0; c < 2; c++) begin
      cur_b[c] = !(ten[c] && present(tv[c], 1'b1));
      cur_c[c] = !(ten[c] && present(tv[c], 1'b0));
    end
    e_np_a = rst1 ? 1'b1 : h_a1;
    e_np_b = (rst1 || rst2) ? 2'b11 : h_b2;
    e_np_c = cur_c;
  endtask

  task automatic advance();
    bit rem;
    h_b2 = h_b1; h_b1 = cur_b; h_a1 = cur_a;
    rst2 = rst1; rst1 = reset;
    if (reset) begin
      for (int b = 0; b < 16; b++) begin m_alloc[b] = 0; m_valid[b] = 0; end
      m_fly_en = 0;
    end else begin
      rem = rem_en && m_alloc[rem_idx];
      if (m_fly_en && !(rem && int'(rem_idx) == m_fly_idx)) begin
        m_valid[m_fly_idx] = 1; m_val[m_fly_idx] = m_fly_val;
      end
      if (rem) begin m_alloc[rem_idx] = 0; m_valid[rem_idx] = 0; end
      if (e_acc) begin
        m_alloc[e_idx] = 1; m_fly_en = 1; m_fly_idx = e_idx; m_fly_val = ins_val;
      end else m_fly_en = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ins_en = 0; rem_en = 0; ten = '0;
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1;
    repeat (n) begin settle(); advance(); end
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    ins_en = 1; ins_val = 4'h9; rem_en = 1; rem_idx = 0;
    settle(); advance();
    settle();
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_a); end
    advance();
    reset = 0; idle();
    settle();
    checks++; if (nv_a !== 5'd0) begin errors++; $display("FAIL reset_nvalid got %0d want 0", nv_a); end
    checks++; if (rdy_a !== 1'b1 || empty_a !== 1'b1) begin errors++; $display("FAIL post_reset_status got rdy=%b empty=%b want 1 1", rdy_a, empty_a); end
    checks++; if (np_a !== 1'b1 || np_b !== 2'b11) begin errors++; $display("FAIL reset_np got a=%b b=%b want 1 11", np_a, np_b); end
    advance();
  endtask

  task automatic test_insert_seq();
    logic [3:0] vals [3];
    vals[0] = 4'h5; vals[1] = 4'h6; vals[2] = 4'h7;
    for (int i = 0; i < 3; i++) begin
      ins_en = 1; ins_val = vals[i];
      settle();
      checks++; if (idx_a !== 4'(i)) begin errors++; $display("FAIL insert_idx got %0d want %0d", idx_a, i); end
      advance();
    end
    idle();
    settle();
    checks++; if (nv_a !== 5'd3) begin errors++; $display("FAIL insert_nvalid got %0d want 3", nv_a); end
    advance();
  endtask

  task automatic test_stage_hit();
    ins_en = 1; ins_val = 4'hA;
    settle(); advance();
    idle(); ten[0] = 1; tv[0] = 4'hA;
    settle();
    checks++; if (np_c[0] !== 1'b0) begin errors++; $display("FAIL stage_hit_lat0 got %b want 0", np_c[0]); end
    advance();
    tv[0] = 4'hB;
    settle();
    checks++; if (np_a !== 1'b0) begin errors++; $display("FAIL stage_hit_lat1 got %b want 0", np_a); end
    advance();
    idle();
    settle();
    checks++; if (np_a !== 1'b1) begin errors++; $display("FAIL absent_lat1 got %b want 1", np_a); end
    advance();
  endtask

  task automatic test_bypass();
    idle(); ins_en = 1; ins_val = 4'h3; ten[0] = 1; tv[0] = 4'h3;
    settle();
    checks++; if (np_c[0] !== 1'b1) begin errors++; $display("FAIL nobypass_lat0 got %b want 1", np_c[0]); end
    advance();
    idle();
    settle();
    checks++; if (np_a !== 1'b1) begin errors++; $display("FAIL nobypass_lat1 got %b want 1", np_a); end
    advance();
    settle();
    checks++; if (np_b[0] !== 1'b0) begin errors++; $display("FAIL bypass_lat2 got %b want 0", np_b[0]); end
    advance();
  endtask

  task automatic test_fill();
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      ins_en = 1; ins_val = 4'(i);
      settle();
      checks++; if (idx_a !== 4'(i)) begin errors++; $display("FAIL fill_idx got %0d want %0d", idx_a, i); end
      advance();
    end
    ins_en = 1; ins_val = 4'hF;
    settle();
    checks++; if (full_a !== 1'b1 || rdy_a !== 1'b0) begin errors++; $display("FAIL full_status got full=%b rdy=%b want 1 0", full_a, rdy_a); end
    advance();
    idle(); rem_en = 1; rem_idx = 4'd9;
    settle();
    checks++; if (nv_a !== 5'd16) begin errors++; $display("FAIL overfill_nvalid got %0d want 16", nv_a); end
    advance();
    ins_en = 1; ins_val = 4'hE; rem_en = 1; rem_idx = 4'd2;
    settle();
    checks++; if (idx_a !== 4'd9 || rdy_a !== 1'b1) begin errors++; $display("FAIL realloc got idx=%0d rdy=%b want 9 1", idx_a, rdy_a); end
    checks++; if (nv_a !== 5'd15) begin errors++; $display("FAIL after_remove_nvalid got %0d want 15", nv_a); end
    advance();
    idle(); rem_en = 1; rem_idx = 4'd2;
    settle();
    checks++; if (nv_a !== 5'd15) begin errors++; $display("FAIL ins_rem_nvalid got %0d want 15", nv_a); end
    advance();
    idle();
    settle();
    checks++; if (nv_a !== 5'd15 || idx_a !== 4'd2) begin errors++; $display("FAIL unalloc_remove got nv=%0d idx=%0d want 15 2", nv_a, idx_a); end
    advance();
  endtask

  task automatic test_remove_wins();
    do_reset(1);
    ins_en = 1; ins_val = 4'hE;
    settle(); advance();
    idle(); rem_en = 1; rem_idx = 4'd0; ten[0] = 1; tv[0] = 4'hE;
    settle();
    checks++; if (np_c[0] !== 1'b0) begin errors++; $display("FAIL conservative_stage got %b want 0", np_c[0]); end
    advance();
    rem_en = 0;
    settle();
    checks++; if (np_c[0] !== 1'b1 || nv_a !== 5'd0) begin errors++; $display("FAIL remove_wins got np=%b nv=%0d want 1 0", np_c[0], nv_a); end
    advance();
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 500; i++) begin
      reset   = (i == 250 || i == 251);
      ins_en  = ($urandom_range(0, 2) != 0);
      ins_val = 4'($urandom);
      rem_en  = ($urandom_range(0, 3) == 0);
      rem_idx = 4'($urandom);
      ten     = 2'($urandom);
      tv[0]   = 4'($urandom);
      tv[1]   = 4'($urandom);
      settle();
      checks++; if (rdy_a !== e_rdy || full_a !== e_full || empty_a !== e_empty) begin
        errors++; $display("FAIL rnd_status cyc %0d got rdy=%b full=%b empty=%b want %b %b %b", i, rdy_a, full_a, empty_a, e_rdy, e_full, e_empty); end
      checks++; if (nv_a !== 5'(e_nv) || nv_b !== 5'(e_nv) || nv_c !== 5'(e_nv)) begin
        errors++; $display("FAIL rnd_nvalid cyc %0d got %0d/%0d/%0d want %0d", i, nv_a, nv_b, nv_c, e_nv); end
      if (e_rdy) begin
        checks++; if (idx_a !== 4'(e_idx)) begin errors++; $display("FAIL rnd_idx cyc %0d got %0d want %0d", i, idx_a, e_idx); end
      end
      checks++; if (np_a !== e_np_a) begin errors++; $display("FAIL rnd_np_lat1 cyc %0d got %b want %b", i, np_a, e_np_a); end
      checks++; if (np_b !== e_np_b) begin errors++; $display("FAIL rnd_np_lat2 cyc %0d got %b want %b", i, np_b, e_np_b); end
      checks++; if (np_c !== e_np_c) begin errors++; $display("FAIL rnd_np_lat0 cyc %0d got %b want %b", i, np_c, e_np_c); end
      if (i == 252) begin
        checks++; if (np_a !== 1'b1 || np_b !== 2'b11 || np_c !== 2'b11 || nv_a !== 5'd0) begin
          errors++; $display("FAIL midreset got a=%b b=%b c=%b nv=%0d want 1 11 11 0", np_a, np_b, np_c, nv_a); end
      end
      advance();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1; idle(); ins_val = '0; rem_idx = '0; tv = '0;
    test_reset();
    test_insert_seq();
    test_stage_hit();
    test_bypass();
    test_fill();
    test_remove_wins();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
